// File: rtl/fifo_pkg.sv
// Shared defaults and elaboration helpers for the parametrised FIFO controller.
package fifo_pkg;

  localparam int DEF_DEPTH    = 16;
  localparam int DEF_AE_LEVEL = 2;

  // Address width for a given power-of-two depth.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Default almost-full threshold: two entries short of full.
  function automatic int def_af_level(input int depth);
    return depth - 2;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around pointer: the extra MSB distinguishes full from empty when addresses match.
module fifo_ptr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // Reset and flush both return the pointer to zero; increments wrap modulo 2^W.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/fifo_ctrl_param.sv
// FIFO pointer/flag controller for a dual-port register file with async read.
module fifo_ctrl_param
  import fifo_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = def_af_level(DEPTH),
  parameter int AE_LEVEL = DEF_AE_LEVEL,
  localparam int ADDR_W  = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              err_clr,
  input  logic              push,
  input  logic              pop,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] r_addr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_LEVEL);

  // Reject illegal parameterisations at elaboration.
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("fifo_ctrl_param: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_ctrl_param: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_ctrl_param: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [PTR_W-1:0] w_ptr;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] count_reg;
  logic [PTR_W-1:0] count_next;
  logic             full_reg;
  logic             empty_reg;
  logic             af_reg;
  logic             ae_reg;
  logic             ovf_reg;
  logic             udf_reg;

  // A pop on a full FIFO frees the slot being written, so push is accepted too.
  assign rd_en = pop & ~empty_reg & ~clr;
  assign wr_en = push & ~clr & (~full_reg | pop);

  assign count_next = count_reg + PTR_W'(wr_en) - PTR_W'(rd_en);

  fifo_ptr #(.W(PTR_W)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (wr_en),
    .ptr (w_ptr)
  );

  fifo_ptr #(.W(PTR_W)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (rd_en),
    .ptr (r_ptr)
  );

  // Occupancy and status flags, all derived from the next count so they never lag.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
      full_reg  <= 1'b0;
      empty_reg <= 1'b1;
      af_reg    <= 1'b0;
      ae_reg    <= 1'b1;
    end else begin
      count_reg <= count_next;
      full_reg  <= (count_next == DEPTH_C);
      empty_reg <= (count_next == '0);
      af_reg    <= (count_next >= AF_C);
      ae_reg    <= (count_next <= AE_C);
    end
  end

  // Sticky errors; a new error event beats a simultaneous err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
      udf_reg <= 1'b0;
    end else begin
      if (push && full_reg && !pop) begin
        ovf_reg <= 1'b1;
      end else if (err_clr) begin
        ovf_reg <= 1'b0;
      end
      if (pop && empty_reg) begin
        udf_reg <= 1'b1;
      end else if (err_clr) begin
        udf_reg <= 1'b0;
      end
    end
  end

  assign w_addr       = w_ptr[ADDR_W-1:0];
  assign r_addr       = r_ptr[ADDR_W-1:0];
  assign count        = count_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = af_reg;
  assign almost_empty = ae_reg;
  assign overflow     = ovf_reg;
  assign underflow    = udf_reg;

  // Pointer distance must always equal the tracked occupancy.
  a_ptr_count : assert property (@(posedge clk) disable iff (rst)
    (PTR_W'(w_ptr - r_ptr) == count_reg));

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Bench for fifo_ctrl_param: a DEPTH=16 and a DEPTH=4 instance share stimulus and
// are each checked every cycle against a queue-based model and a bench-side register file.
module tb_fifo_ctrl_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr, err_clr, push, pop;

  logic       wr_en_a, rd_en_a, full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
  logic [3:0] w_addr_a, r_addr_a;
  logic [4:0] count_a;

  logic       wr_en_b, rd_en_b, full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
  logic [1:0] w_addr_b, r_addr_b;
  logic [2:0] count_b;

  fifo_ctrl_param dut16 (
    .clk(clk), .rst(rst), .clr(clr), .err_clr(err_clr), .push(push), .pop(pop),
    .wr_en(wr_en_a), .rd_en(rd_en_a), .w_addr(w_addr_a), .r_addr(r_addr_a),
    .count(count_a), .full(full_a), .empty(empty_a), .almost_full(af_a),
    .almost_empty(ae_a), .overflow(ovf_a), .underflow(udf_a)
  );

  fifo_ctrl_param #(.DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut4 (
    .clk(clk), .rst(rst), .clr(clr), .err_clr(err_clr), .push(push), .pop(pop),
    .wr_en(wr_en_b), .rd_en(rd_en_b), .w_addr(w_addr_b), .r_addr(r_addr_b),
    .count(count_b), .full(full_b), .empty(empty_b), .almost_full(af_b),
    .almost_empty(ae_b), .overflow(ovf_b), .underflow(udf_b)
  );

  typedef struct {
    int wr, rd, wa, ra, cnt, full, empty, af, ae, ovf, udf;
  } obs_t;

  typedef struct {
    bit push, pop, clr, err_clr;
    int wr, rd, cnt, full, empty, af, ae, ovf, udf, wa, ra;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: contents as a queue, addresses as accepted-transfer counts mod depth.
  int         md  [2] = '{16, 4};
  int         maf [2] = '{14, 3};
  int         mae [2] = '{2, 1};
  logic [7:0] mq  [2][$];
  int         mwi [2];
  int         mri [2];
  int         movf[2];
  int         mudf[2];
  logic [7:0] mem [2][16];
  logic [7:0] data_ctr = 8'h01;
  int         last_wr_a, last_rd_a;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t get_obs(input int k);
    obs_t o;
    if (k == 0) begin
      o.wr = int'(wr_en_a); o.rd = int'(rd_en_a); o.wa = int'(w_addr_a); o.ra = int'(r_addr_a);
      o.cnt = int'(count_a); o.full = int'(full_a); o.empty = int'(empty_a); o.af = int'(af_a);
      o.ae = int'(ae_a); o.ovf = int'(ovf_a); o.udf = int'(udf_a);
    end else begin
      o.wr = int'(wr_en_b); o.rd = int'(rd_en_b); o.wa = int'(w_addr_b); o.ra = int'(r_addr_b);
      o.cnt = int'(count_b); o.full = int'(full_b); o.empty = int'(empty_b); o.af = int'(af_b);
      o.ae = int'(ae_b); o.ovf = int'(ovf_b); o.udf = int'(udf_b);
    end
    return o;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mwi[k] = 0; mri[k] = 0; movf[k] = 0; mudf[k] = 0;
    end
  endtask

  // One clock cycle: drive, check against the model, clock, update model and memory.
  task automatic step(input bit p, input bit po, input bit c, input bit ec, input bit r);
    int   sz, exp_wr, exp_rd;
    int   wr_s [2];
    int   wa_s [2];
    obs_t o;
    string pre;
    push = p; pop = po; clr = c; err_clr = ec; rst = r;
    #1;
    for (int k = 0; k < 2; k++) begin
      o = get_obs(k);
      pre = $sformatf("d%0d", md[k]);
      sz = mq[k].size();
      exp_rd = (po && !c && sz > 0) ? 1 : 0;
      exp_wr = (p && !c && (sz < md[k] || po)) ? 1 : 0;
      chk({pre, ".wr_en"}, o.wr, exp_wr);
      chk({pre, ".rd_en"}, o.rd, exp_rd);
      chk({pre, ".count"}, o.cnt, sz);
      chk({pre, ".w_addr"}, o.wa, mwi[k]);
      chk({pre, ".r_addr"}, o.ra, mri[k]);
      chk({pre, ".full"}, o.full, (sz == md[k]) ? 1 : 0);
      chk({pre, ".empty"}, o.empty, (sz == 0) ? 1 : 0);
      chk({pre, ".almost_full"}, o.af, (sz >= maf[k]) ? 1 : 0);
      chk({pre, ".almost_empty"}, o.ae, (sz <= mae[k]) ? 1 : 0);
      chk({pre, ".overflow"}, o.ovf, movf[k]);
      chk({pre, ".underflow"}, o.udf, mudf[k]);
      if (exp_rd == 1) chk({pre, ".rd_data"}, int'(mem[k][o.ra]), int'(mq[k][0]));
      wr_s[k] = o.wr;
      wa_s[k] = o.wa;
      if (k == 0) begin
        last_wr_a = o.wr;
        last_rd_a = o.rd;
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (wr_s[k] == 1) mem[k][wa_s[k]] = data_ctr;
      sz = mq[k].size();
      if (r) begin
        mq[k].delete();
        mwi[k] = 0; mri[k] = 0; movf[k] = 0; mudf[k] = 0;
      end else begin
        if (p && sz == md[k] && !po) movf[k] = 1;
        else if (ec) movf[k] = 0;
        if (po && sz == 0) mudf[k] = 1;
        else if (ec) mudf[k] = 0;
        if (c) begin
          mq[k].delete();
          mwi[k] = 0; mri[k] = 0;
        end else begin
          if (po && sz > 0) begin
            void'(mq[k].pop_front());
            mri[k] = (mri[k] + 1) % md[k];
          end
          if (p && (sz < md[k] || po)) begin
            mq[k].push_back(data_ctr);
            mwi[k] = (mwi[k] + 1) % md[k];
          end
        end
      end
    end
    data_ctr = data_ctr + 8'd1;
    @(negedge clk);
  endtask

  vec_t tbl [13];

  initial begin
    // push, pop, clr, err_clr | wr, rd | cnt, full, empty, af, ae | ovf, udf | wa, ra
    tbl[0]  = '{1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 1, 0};
    tbl[1]  = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0};
    tbl[2]  = '{1, 0, 0, 0, 1, 0, 2, 0, 0, 0, 1, 0, 0, 2, 0};
    tbl[3]  = '{1, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 3, 0};
    tbl[4]  = '{0, 1, 0, 0, 0, 1, 2, 0, 0, 0, 1, 0, 0, 3, 1};
    tbl[5]  = '{1, 1, 0, 0, 1, 1, 2, 0, 0, 0, 1, 0, 0, 4, 2};
    tbl[6]  = '{0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 4, 3};
    tbl[7]  = '{0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 4, 4};
    tbl[8]  = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 4, 4};
    tbl[9]  = '{0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 4, 4};
    tbl[10] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 4, 4};
    tbl[11] = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 5, 4};
    tbl[12] = '{1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};

    rst = 1'b1; clr = 1'b0; err_clr = 1'b0; push = 1'b0; pop = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();

    // Reset state of the DEPTH=16 instance.
    chk("reset.count", int'(count_a), 0);
    chk("reset.empty", int'(empty_a), 1);
    chk("reset.almost_empty", int'(ae_a), 1);
    chk("reset.full", int'(full_a), 0);
    chk("reset.almost_full", int'(af_a), 0);
    chk("reset.w_addr", int'(w_addr_a), 0);
    chk("reset.r_addr", int'(r_addr_a), 0);
    chk("reset.overflow", int'(ovf_a), 0);
    chk("reset.underflow", int'(udf_a), 0);

    // Table-driven directed vectors on the DEPTH=16 instance.
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].push, tbl[i].pop, tbl[i].clr, tbl[i].err_clr, 0);
      chk($sformatf("tbl%0d.wr_en", i), last_wr_a, tbl[i].wr);
      chk($sformatf("tbl%0d.rd_en", i), last_rd_a, tbl[i].rd);
      chk($sformatf("tbl%0d.count", i), int'(count_a), tbl[i].cnt);
      chk($sformatf("tbl%0d.full", i), int'(full_a), tbl[i].full);
      chk($sformatf("tbl%0d.empty", i), int'(empty_a), tbl[i].empty);
      chk($sformatf("tbl%0d.af", i), int'(af_a), tbl[i].af);
      chk($sformatf("tbl%0d.ae", i), int'(ae_a), tbl[i].ae);
      chk($sformatf("tbl%0d.ovf", i), int'(ovf_a), tbl[i].ovf);
      chk($sformatf("tbl%0d.udf", i), int'(udf_a), tbl[i].udf);
      chk($sformatf("tbl%0d.w_addr", i), int'(w_addr_a), tbl[i].wa);
      chk($sformatf("tbl%0d.r_addr", i), int'(r_addr_a), tbl[i].ra);
    end

    // Fill to full: almost_full at 14, full at 16, write address wraps to 0.
    step(0, 0, 0, 0, 1);
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 0, 0, 0);
      chk($sformatf("fill%0d.count", i), int'(count_a), i);
      chk($sformatf("fill%0d.af", i), int'(af_a), (i >= 14) ? 1 : 0);
      chk($sformatf("fill%0d.full", i), int'(full_a), (i == 16) ? 1 : 0);
      chk($sformatf("fill%0d.w_addr", i), int'(w_addr_a), i % 16);
      chk($sformatf("fill%0d.ovf", i), int'(ovf_a), 0);
    end

    // Push on full without pop: rejected, overflow latches, then err_clr clears it.
    step(1, 0, 0, 0, 0);
    chk("ovf.wr_en", last_wr_a, 0);
    chk("ovf.count", int'(count_a), 16);
    chk("ovf.flag", int'(ovf_a), 1);
    step(0, 0, 0, 1, 0);
    chk("ovf_clr.flag", int'(ovf_a), 0);

    // Push and pop together on full: count holds, both addresses advance in lockstep.
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 0, 0);
      chk($sformatf("pp%0d.accept", i), last_wr_a + last_rd_a, 2);
      chk($sformatf("pp%0d.count", i), int'(count_a), 16);
      chk($sformatf("pp%0d.w_addr", i), int'(w_addr_a), (i + 1) % 16);
      chk($sformatf("pp%0d.r_addr", i), int'(r_addr_a), (i + 1) % 16);
    end

    // Flush with a simultaneous push keeps sticky errors; then reset mid-traffic.
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    chk("clr.count", int'(count_a), 0);
    chk("clr.empty", int'(empty_a), 1);
    chk("clr.w_addr", int'(w_addr_a), 0);
    chk("clr.r_addr", int'(r_addr_a), 0);
    chk("clr.underflow", int'(udf_a), 1);
    chk("clr.overflow", int'(ovf_a), 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    chk("pre_rst.count", int'(count_a), 5);
    step(1, 1, 0, 0, 1);
    chk("rst.count", int'(count_a), 0);
    chk("rst.empty", int'(empty_a), 1);
    chk("rst.almost_empty", int'(ae_a), 1);
    chk("rst.w_addr", int'(w_addr_a), 0);
    chk("rst.underflow", int'(udf_a), 0);

    // Randomised traffic with phases of rising, balanced and falling occupancy.
    for (int i = 0; i < 10000; i++) begin
      int  ph;
      bit  rp, rpo, rc, rec, rr;
      ph  = (i / 300) % 3;
      rp  = ($urandom_range(3, 0) < 3 - ph);
      rpo = ($urandom_range(3, 0) < 1 + ph);
      rc  = ($urandom_range(99, 0) == 0);
      rec = ($urandom_range(39, 0) == 0);
      rr  = ($urandom_range(999, 0) == 0);
      step(rp, rpo, rc, rec, rr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_param.md
# fifo_ctrl_param

Parametrised FIFO pointer/flag controller, the next generation of the 16-entry UART FIFO control unit. It generates write/read addresses, accepted-transfer strobes, an occupancy count, full/empty and programmable almost-full/almost-empty flags, and sticky overflow/underflow errors. It sits between the UART RX/TX paths (or sensor capture logic) and a simple dual-port register file with synchronous write and asynchronous read. Unlike its predecessor, it supports any power-of-two depth, exposes occupancy, and accepts push and pop together even when the FIFO is full.

## Interface
- DEPTH, 16: number of entries; power of two, ≥ 2. ADDR_W = $clog2(DEPTH).
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- clr  in  1  synchronous flush; empties the FIFO and leaves sticky errors untouched.
- err_clr  in  1  synchronous clear of overflow/underflow.
- push  in  1  write request.
- pop  in  1  read request.
- wr_en  out  1  combinational; push accepted this cycle; drives memory write enable.
- rd_en  out  1  combinational; pop accepted this cycle; the consumer takes data at r_addr.
- w_addr  out  ADDR_W  current write address (lower bits of the write pointer).
- r_addr  out  ADDR_W  current read address.
- count  out  ADDR_W+1  registered occupancy, 0..DEPTH.
- full, empty, almost_full, almost_empty  out  1  registered status flags.
- overflow, underflow  out  1  sticky error flags.

## Operation
- Pointers are ADDR_W+1 bits wide; the MSB is the wrap bit. Increments are modulo 2^(ADDR_W+1), so wrap-around is natural.
- Acceptance (combinational, from registered flags):
  - rd_en = pop & !empty & !clr.
  - wr_en = push & !clr & (!full | pop).
- Push and pop on a full FIFO: both are accepted, count is unchanged, and r_addr equals w_addr. The memory must return the old data (async read in the same cycle as the write).
- Push and pop on an empty FIFO: only the push is accepted and count becomes 1. The pop is rejected and sets underflow.
- Next count = count + wr_en - rd_en. Flags are computed from the next count and registered:
  - full when count = DEPTH.
  - empty when count = 0.
  - almost_full when count ≥ AF_LEVEL.
  - almost_empty when count ≤ AE_LEVEL.
- overflow is set by push & full & !pop. underflow is set by pop & empty. Both hold until err_clr or rst. A set event in the same cycle as err_clr wins.
- Priority: rst > clr > push/pop. clr zeroes the pointers and count and sets empty=1, almost_empty=1, full=0, almost_full=0.
- There is no FSM. State is the write pointer, read pointer, count, four flags and two error bits. Pointer equality serves only as an assertion cross-check against count.

## Timing
- Reset values: w_addr=0, r_addr=0, count=0, empty=1, almost_empty=1 (the AE_LEVEL≥0 rule holds), full=0, almost_full=0, overflow=0, underflow=0. wr_en and rd_en follow their equations.
- An asserted rst in the middle of traffic discards all contents at that edge. Requests in that cycle are ignored.
- Latency:
  - An accepted push is visible in count, empty and w_addr one edge later. The first data is poppable in the next cycle.
  - An accepted pop advances r_addr at the edge, and its data is valid during the rd_en cycle.
  - Flags never lag count.
- wr_en and rd_en depend on push, pop and clr combinationally. There is no other combinational path from input to output.

## Structure
- Package fifo_pkg holds the DEPTH and threshold defaults and a clog2-based ADDR_W helper. The legality checks on DEPTH and the levels are elaboration-time asserts.
- One sub-module, fifo_ptr: an ADDR_W+1-bit wrap counter with clr and inc. It is instantiated twice, for the write side and the read side.
- Target size is about 150 lines of RTL.

## Test plan
- Reset, then push 16 times with DEPTH=16 → count 0→16. almost_full rises when count reaches 14. full=1 after the 16th edge. w_addr wraps to 0. overflow stays 0.
- Push on full without pop → wr_en=0, count stays 16, overflow=1 next cycle. err_clr → overflow=0.
- Push and pop together on full for 20 cycles → count stays 16, both addresses advance each cycle and wrap. Data read out follows FIFO order.
- Push and pop together on empty → wr_en=1, rd_en=0, count=1, empty=0, underflow=1.
- Fill 10, then clr and push together → count=0, empty=1, addresses 0, overflow/underflow unchanged. Then assert rst with count=5 → all reset values appear after the edge.
- DEPTH=4, AF_LEVEL=3, AE_LEVEL=1, random push/pop for 10k cycles → scoreboard matches data and flags every cycle. Pointer difference equals count at all times.
